fpu_acc: RTL
============

Name: fpu_acc

Overview:
- FP16 (IEEE 754 binary16) accumulator placed directly downstream of the half-precision multiplier.
- Consumes each product that the multiplier presents on its result/valid pulse and adds it into an internal running sum.
- The sum is exposed to the peripheral register interface, forming a multiply-accumulate path.
- Multi-cycle, non-pipelined datapath with a one-entry pending buffer so back-to-back products are not lost.

Parameters:
- None. Format fixed at FP16: sign bit 15, exponent [14:10] with bias 15, mantissa [9:0].

Ports:
- clk       input   1   system clock, rising edge
- rst_n     input   1   asynchronous active-low reset
- in_valid  input   1   one-cycle pulse; in_data is a product to accumulate
- in_data   input   16  FP16 product, driven from the multiplier result
- clear     input   1   synchronous: accumulator := +0, abort operation
- busy      output  1   high whenever state != IDLE
- acc_valid output  1   one-cycle pulse when acc_out is updated
- acc_out   output  16  current FP16 accumulator value
- drop_err  output  1   sticky; an input was discarded for lack of buffer space

Behaviour:
- Reset (asynchronous, rst_n low) values:
  - state = IDLE; acc_out = 16'h0000; acc_valid = 0; drop_err = 0; pending empty.
  - Any operation in flight is abandoned.
- States: IDLE -> ALIGN -> ADD -> NORM -> PACK -> (IDLE, or ALIGN if pending full).
- Accept and latency:
  - In IDLE, in_valid=1 latches in_data as operand B at edge E0; operand A = acc_out.
  - acc_out is updated and acc_valid=1 for exactly one cycle after edge E4 (4-cycle latency).
- Pending buffer (1 entry):
  - in_valid while busy and pending empty -> in_data is stored in pending.
  - in_valid while busy and pending full, in a state other than PACK -> in_data is dropped and drop_err := 1.
  - In PACK with pending full: pending becomes the next operand B (next state ALIGN, A = new acc value). A simultaneous in_valid in that cycle is stored in pending; nothing is dropped.
- clear:
  - Priority over everything except reset.
  - Effects: acc_out := 0000, pending emptied, state := IDLE, drop_err := 0, acc_valid := 0.
  - Any in_valid in the same cycle is ignored.
- Decode:
  - exp==0 is treated as zero (denormals flush to zero).
  - exp==31 with mantissa!=0 is NaN; exp==31 with mantissa==0 is infinity.
- Specials, resolved in PACK, in priority order:
  - Either operand NaN -> 7E00.
  - +inf plus -inf -> 7E00.
  - Either operand inf -> that inf.
  - Both operands zero -> +0 (0000), except -0 + -0 = 8000.
- ALIGN:
  - Significands are 11 bits with the hidden 1.
  - Swap so operand X has the larger magnitude (compare exp, then mantissa).
  - Shift Y right by (expX - expY); shifted-out bits are discarded (truncate).
  - A difference >= 11 makes Y zero.
- ADD:
  - 12-bit sum if signs are equal, else X - Y.
  - Result sign = sign of X.
  - Exact cancellation -> +0 (0000).
- NORM:
  - If bit 11 is set: shift right by 1, exp + 1.
  - Else: left-shift so bit 10 is set, exp minus the shift count (single-cycle leading-zero count).
  - Use a 7-bit signed working exponent.
- PACK:
  - exp >= 31 -> signed infinity.
  - exp <= 0 -> signed zero.
  - Otherwise {sign, exp[4:0], mant[9:0]}.
  - Rounding is truncation throughout.
- acc_out holds its value between updates and is never driven with intermediate values.

Optional Feature:
- Macro: FPU_ACC_COUNT_EN.
- When defined:
  - Adds output acc_count [7:0], reset to 0 and cleared by clear.
  - Increments by 1 on each acc_valid pulse, saturating at 255.
  - Dropped inputs are not counted.
- When undefined:
  - Port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then in_valid with 3C00, wait; in_valid with 3C00 -> acc_out 3C00, then 4000. Each acc_valid follows its in_valid by 4 cycles; busy is high for 4 cycles.
- Accumulate 3C00 then BC00 -> acc_out 3C00, then 0000 (exact cancel gives +0).
- Accumulate 7C00 then FC00 -> 7E00. Then accumulate 3C00 -> stays 7E00 (NaN sticky through the sum).
- Accumulate 7BFF twice -> 7BFF, then 7C00 (overflow to +inf).
- Three in_valid pulses on consecutive cycles (3C00 each):
  - first is processed, second is pending, third is dropped and drop_err=1;
  - final acc_out 4000 after two acc_valid pulses;
  - with FPU_ACC_COUNT_EN, acc_count=2.
- Two further cases:
  - assert clear during ADD -> no acc_valid, acc_out 0000, drop_err 0, busy low next cycle;
  - drop rst_n mid-NORM -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/fpu_acc.sv
// fpu_acc: FP16 running-sum accumulator fed by the half-precision multiplier.
// Define FPU_ACC_COUNT_EN to add acc_count, a saturating count of accumulator updates.
module fpu_acc (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  input  logic        clear,
  output logic        busy,
  output logic        acc_valid,
  output logic [15:0] acc_out,
  output logic        drop_err
`ifdef FPU_ACC_COUNT_EN
  ,
  output logic [7:0]  acc_count
`endif
);

  typedef enum logic [2:0] {StIdle, StAlign, StAdd, StNorm, StPack} state_e;

  state_e             state_q, state_d;
  logic [15:0]        acc_q, acc_d, b_q, b_d, pend_q, pend_d;
  logic               pend_full_q, pend_full_d, valid_q, valid_d, drop_q, drop_d;
  logic               sign_q, sub_q, spec_q;
  logic [15:0]        spec_res_q;
  logic signed [6:0]  exp_q;
  logic [10:0]        mx_q, my_q, mant_q;
  logic [11:0]        sum_q;

  logic [4:0]         ea, eb, ex, ey, ediff;
  logic               a_zero, a_inf, a_nan, b_zero, b_inf, b_nan, a_big, spec;
  logic [10:0]        sig_a, sig_b, sx, sy, norm_mant;
  logic [15:0]        spec_res, pack_res;
  logic [3:0]         lz;
  logic signed [6:0]  norm_exp;

  // Operand decode, magnitude swap and special-case resolution (A = acc, B = new product)
  always_comb begin
    ea     = acc_q[14:10];
    eb     = b_q[14:10];
    a_zero = (ea == 5'd0);
    b_zero = (eb == 5'd0);
    a_inf  = (ea == 5'd31) && (acc_q[9:0] == 10'd0);
    b_inf  = (eb == 5'd31) && (b_q[9:0] == 10'd0);
    a_nan  = (ea == 5'd31) && (acc_q[9:0] != 10'd0);
    b_nan  = (eb == 5'd31) && (b_q[9:0] != 10'd0);
    sig_a  = a_zero ? 11'd0 : {1'b1, acc_q[9:0]};
    sig_b  = b_zero ? 11'd0 : {1'b1, b_q[9:0]};
    a_big  = {ea, acc_q[9:0]} >= {eb, b_q[9:0]};
    ex     = a_big ? ea : eb;
    ey     = a_big ? eb : ea;
    sx     = a_big ? sig_a : sig_b;
    sy     = a_big ? sig_b : sig_a;
    ediff  = ex - ey;
    spec     = 1'b1;
    spec_res = 16'h0000;
    if (a_nan || b_nan) begin
      spec_res = 16'h7e00;
    end else if (a_inf && b_inf && (acc_q[15] != b_q[15])) begin
      spec_res = 16'h7e00;
    end else if (a_inf) begin
      spec_res = acc_q;
    end else if (b_inf) begin
      spec_res = b_q;
    end else if (a_zero && b_zero) begin
      spec_res = {acc_q[15] & b_q[15], 15'd0};
    end else begin
      spec = 1'b0;
    end
  end

  // Leading-zero count over the 11-bit sum; highest set bit wins
  always_comb begin
    lz = 4'd11;
    for (int i = 0; i <= 10; i++) begin
      if (sum_q[i]) lz = 4'(10 - i);
    end
    if (sum_q[11]) begin
      norm_mant = sum_q[11:1];
      norm_exp  = exp_q + 7'sd1;
    end else begin
      norm_mant = sum_q[10:0] << lz;
      norm_exp  = exp_q - $signed({3'b000, lz});
    end
  end

  // A zero normalised mantissa means exact cancellation
  always_comb begin
    if (spec_q)                pack_res = spec_res_q;
    else if (!mant_q[10])      pack_res = 16'h0000;
    else if (exp_q >= 7'sd31)  pack_res = {sign_q, 5'h1f, 10'h000};
    else if (exp_q <= 7'sd0)   pack_res = {sign_q, 15'h0000};
    else                       pack_res = {sign_q, exp_q[4:0], mant_q[9:0]};
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    b_d         = b_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    valid_d     = 1'b0;
    drop_d      = drop_q;
    if (clear) begin
      state_d     = StIdle;
      acc_d       = 16'h0000;
      pend_full_d = 1'b0;
      drop_d      = 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (pend_full_q) begin
            b_d         = pend_q;
            state_d     = StAlign;
            pend_full_d = in_valid;
            if (in_valid) pend_d = in_data;
          end else if (in_valid) begin
            b_d     = in_data;
            state_d = StAlign;
          end
        end
        StAlign, StAdd, StNorm: begin
          state_d = (state_q == StAlign) ? StAdd : (state_q == StAdd) ? StNorm : StPack;
          if (in_valid) begin
            if (!pend_full_q) begin
              pend_d      = in_data;
              pend_full_d = 1'b1;
            end else begin
              drop_d = 1'b1;
            end
          end
        end
        StPack: begin
          acc_d   = pack_res;
          valid_d = 1'b1;
          if (pend_full_q) begin
            b_d         = pend_q;
            state_d     = StAlign;
            pend_full_d = in_valid;
            if (in_valid) pend_d = in_data;
          end else begin
            state_d = StIdle;
            if (in_valid) begin
              pend_d      = in_data;
              pend_full_d = 1'b1;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      acc_q       <= 16'h0000;
      b_q         <= 16'h0000;
      pend_q      <= 16'h0000;
      pend_full_q <= 1'b0;
      valid_q     <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      b_q         <= b_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      valid_q     <= valid_d;
      drop_q      <= drop_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_q     <= 1'b0;
      sub_q      <= 1'b0;
      spec_q     <= 1'b0;
      spec_res_q <= 16'h0000;
      exp_q      <= 7'sd0;
      mx_q       <= 11'd0;
      my_q       <= 11'd0;
      sum_q      <= 12'd0;
      mant_q     <= 11'd0;
    end else begin
      case (state_q)
        StAlign: begin
          sign_q     <= a_big ? acc_q[15] : b_q[15];
          sub_q      <= acc_q[15] ^ b_q[15];
          exp_q      <= {2'b00, ex};
          mx_q       <= sx;
          my_q       <= (ediff >= 5'd11) ? 11'd0 : (sy >> ediff);
          spec_q     <= spec;
          spec_res_q <= spec_res;
        end
        StAdd:  sum_q <= sub_q ? ({1'b0, mx_q} - {1'b0, my_q}) : ({1'b0, mx_q} + {1'b0, my_q});
        StNorm: begin
          exp_q  <= norm_exp;
          mant_q <= norm_mant;
        end
        default: ;
      endcase
    end
  end

`ifdef FPU_ACC_COUNT_EN
  logic [7:0] count_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           count_q <= 8'd0;
    else if (clear)                       count_q <= 8'd0;
    else if (valid_d && count_q != 8'hff) count_q <= count_q + 8'd1;
  end
  assign acc_count = count_q;
`endif

  assign busy      = (state_q != StIdle);
  assign acc_valid = valid_q;
  assign acc_out   = acc_q;
  assign drop_err  = drop_q;

endmodule
